// File: rtl/imem.sv
// Instruction memory responder: valid/ready fetch slave with
// programmable wait states and a separate program-load port.
module imem #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        resp_ready,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req_err;
  logic          load_ok;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;
  logic          unused_load_lsb;

  assign req_idx  = req_addr[AW+1:2];
  assign load_idx = load_addr[AW+1:2];
  assign req_err  = (req_addr[1:0] != 2'b00)
                 || (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign load_ok  = load_addr[31:2] < 30'(DEPTH_WORDS);
  assign unused_load_lsb = ^load_addr[1:0];

  // Contents survive reset; only the loader writes them.
  always_ff @(posedge clk) begin
    if (load_en && load_ok)
      mem[load_idx] <= load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_instr <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            // Non-blocking read returns the pre-load word.
            resp_instr <= req_err ? 32'd0 : mem[req_idx];
            resp_err   <= req_err;
            cnt        <= 4'(LATENCY - 1);
            req_ready  <= 1'b0;
            if (LATENCY == 1) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem.sv
// Directed bench for imem: LATENCY=2 main instance plus a
// LATENCY=1 instance for back-to-back throughput.
module tb_imem;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, resp_valid, resp_err, resp_ready;
  logic [31:0] req_addr, resp_instr;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  logic        r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_err;
  logic        r1_resp_ready;
  logic [31:0] r1_req_addr, r1_resp_instr;
  logic        r1_load_en;
  logic [31:0] r1_load_addr, r1_load_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instr(resp_instr),
    .resp_err(resp_err), .resp_ready(resp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(r1_req_valid), .req_addr(r1_req_addr),
    .req_ready(r1_req_ready),
    .resp_valid(r1_resp_valid), .resp_instr(r1_resp_instr),
    .resp_err(r1_resp_err), .resp_ready(r1_resp_ready),
    .load_en(r1_load_en), .load_addr(r1_load_addr),
    .load_data(r1_load_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic load1(input logic [31:0] a, input logic [31:0] d);
    r1_load_en = 1'b1; r1_load_addr = a; r1_load_data = d;
    step();
    r1_load_en = 1'b0;
  endtask

  // LATENCY=2: accept edge -> WAIT, next edge -> RESP, next -> IDLE.
  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] ei, input logic ee);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = a;
    step();
    req_valid = 1'b0;
    chk({tag, "_wait_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_instr"}, resp_instr, ei);
    chk({tag, "_err"}, 32'(resp_err), 32'(ee));
    step();
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    r1_req_valid = 1'b0; r1_req_addr = '0; r1_resp_ready = 1'b1;
    r1_load_en = 1'b0; r1_load_addr = '0; r1_load_data = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_instr", resp_instr, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    step();

    load(32'h0, 32'h2008_0005);
    load(32'h4, 32'h2009_0003);
    load(32'h8, 32'h1111_1111);

    fetch("f0", 32'h0, 32'h2008_0005, 1'b0);
    fetch("f4", 32'h4, 32'h2009_0003, 1'b0);
    fetch("mis", 32'h6, 32'h0, 1'b1);
    fetch("oor", 32'h400, 32'h0, 1'b1);

    // Backpressure in RESP for 5 cycles.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_instr", resp_instr, 32'h2009_0003);
      chk("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("bp_rel_valid", 32'(resp_valid), 32'd0);
    chk("bp_rel_ready", 32'(req_ready), 32'd1);

    // Load and accept to the same word in one cycle.
    req_valid = 1'b1; req_addr = 32'h8;
    load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0; load_en = 1'b0;
    step();
    chk("rbw_valid", 32'(resp_valid), 32'd1);
    chk("rbw_instr", resp_instr, 32'h1111_1111);
    step();
    fetch("f8_new", 32'h8, 32'hDEAD_BEEF, 1'b0);

    // Reset during WAIT aborts the request.
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    chk("ab_wait_ready", 32'(req_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("ab_ready", 32'(req_ready), 32'd1);
    chk("ab_valid", 32'(resp_valid), 32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_no_resp", 32'(resp_valid), 32'd0);
    end
    // Out-of-range load must not alias onto word 0.
    load(32'h400, 32'h0BAD_0BAD);
    fetch("ab_mem", 32'h0, 32'h2008_0005, 1'b0);

    // LATENCY=1 back-to-back with resp_ready tied high.
    load1(32'h0, 32'hAAAA_0001);
    load1(32'h4, 32'hAAAA_0002);
    r1_req_valid = 1'b1; r1_req_addr = 32'h0;
    step();
    chk("l1_valid_a", 32'(r1_resp_valid), 32'd1);
    chk("l1_instr_a", r1_resp_instr, 32'hAAAA_0001);
    r1_req_addr = 32'h4;
    step();
    chk("l1_idle_valid", 32'(r1_resp_valid), 32'd0);
    chk("l1_idle_ready", 32'(r1_req_ready), 32'd1);
    step();
    chk("l1_valid_b", 32'(r1_resp_valid), 32'd1);
    chk("l1_instr_b", r1_resp_instr, 32'hAAAA_0002);
    chk("l1_err_b", 32'(r1_resp_err), 32'd0);
    r1_req_valid = 1'b0;
    step();
    chk("l1_end", 32'(r1_resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
